// File: rtl/c432_key_loader.sv
// c432_key_loader
//
// Upstream key loader for the key-locked c432 interrupt-priority netlist.
// Receives the unlock key p1..p8 as a serial frame of KEY_W data bits and
// one even-parity bit. The bits are collected in a shadow register. The key
// is committed to key_out in one step, and only when the parity checks.
// After MAX_FAIL consecutive bad frames the loader locks out until rst.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst        synchronous, active-high reset
//   start      one-cycle request to begin (or restart) a key frame
//   sin_data   serial key / parity bit
//   sin_valid  sin_data is valid this cycle
//   sin_ready  loader accepts a bit this cycle (registered, high in DATA/PAR)
//   key_out    committed key; key_out[0] drives p1 ... key_out[7] drives p8
//   key_ok     key_out holds a parity-checked key
//   busy       a frame is in progress
//   err        one-cycle pulse after a parity failure
//   lockout    sticky; the loader refuses further frames until rst
//   fail_cnt   consecutive parity-failure count, saturating at MAX_FAIL
//
// Handshake: a bit transfers on a rising edge where sin_valid and sin_ready
// are both 1. The source must hold sin_data and sin_valid until that edge.
// A start in the same cycle wins, and the bit is discarded.
module c432_key_loader #(
  parameter int KEY_W    = 8,
  parameter int MAX_FAIL = 3,
  parameter int FCW      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin_data,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_ok,
  output logic             busy,
  output logic             err,
  output logic             lockout,
  output logic [FCW-1:0]   fail_cnt
);

  localparam int CW = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    LOCK = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [KEY_W-1:0] shadow;
  logic [CW-1:0]    cnt;
  logic             parity;

  logic             xfer;
  logic             clr_frame;
  logic             load_bit;
  logic             commit;
  logic             fail;
  logic             enter_lock;
  logic [FCW-1:0]   fail_cnt_inc;

  // Only DATA and PAR raise sin_ready, so xfer can never fire in IDLE or LOCK.
  assign xfer = sin_valid && sin_ready && !start;

  assign fail_cnt_inc = (fail_cnt == FCW'(MAX_FAIL)) ? fail_cnt
                                                     : fail_cnt + 1'b1;

  always_comb begin
    state_next = state;
    clr_frame  = 1'b0;
    load_bit   = 1'b0;
    commit     = 1'b0;
    fail       = 1'b0;
    enter_lock = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr_frame  = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (start) begin
          clr_frame  = 1'b1;
          state_next = DATA;
        end else if (xfer) begin
          load_bit = 1'b1;
          if (cnt == CW'(KEY_W - 1)) state_next = PAR;
        end
      end
      PAR: begin
        if (start) begin
          clr_frame  = 1'b1;
          state_next = DATA;
        end else if (xfer) begin
          // Even parity: data bits XOR parity bit must be 0.
          if (parity ^ sin_data) begin
            fail = 1'b1;
            if (fail_cnt_inc == FCW'(MAX_FAIL)) begin
              enter_lock = 1'b1;
              state_next = LOCK;
            end else begin
              state_next = IDLE;
            end
          end else begin
            commit     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      LOCK: begin
        state_next = LOCK;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      cnt       <= '0;
      parity    <= 1'b0;
      sin_ready <= 1'b0;
      key_out   <= '0;
      key_ok    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      lockout   <= 1'b0;
      fail_cnt  <= '0;
    end else begin
      state     <= state_next;
      // These outputs are decoded from the next state so that they line up
      // with the registered state.
      sin_ready <= (state_next == DATA) || (state_next == PAR);
      busy      <= (state_next == DATA) || (state_next == PAR);
      lockout   <= (state_next == LOCK);
      err       <= fail;

      if (clr_frame) begin
        cnt    <= '0;
        parity <= 1'b0;
      end
      if (load_bit) begin
        shadow[cnt] <= sin_data;
        parity      <= parity ^ sin_data;
        cnt         <= cnt + 1'b1;
      end
      if (commit) begin
        key_out  <= shadow;
        key_ok   <= 1'b1;
        fail_cnt <= '0;
      end
      if (fail) begin
        fail_cnt <= fail_cnt_inc;
      end
      if (enter_lock) begin
        key_out <= '0;
        key_ok  <= 1'b0;
      end
    end
  end

endmodule
